// File: rtl/shift_reg_serializer.sv
// Parallel-load shift register that drains a REG_WIDTH word one bit per enabled cycle.
// Define SHIFT_ROTATE_EN to rotate the shifted-out bit back in instead of taking serial_in.
module shift_reg_serializer #(
    parameter int REG_WIDTH = 8,
    localparam int CNT_W = $clog2(REG_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift_left_right,
    input  logic                 shift_en,
    input  logic                 serial_in,
    input  logic [REG_WIDTH-1:0] data_in,
    output logic [REG_WIDTH-1:0] data_out,
    output logic                 serial_out,
    output logic [CNT_W-1:0]     shift_cnt,
    output logic                 busy,
    output logic                 drained,
    output logic [1:0]           state
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOADED   = 2'd1;
    localparam logic [1:0] SHIFTING = 2'd2;
    localparam logic [1:0] DRAINED  = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_WIDTH - 1);

    logic                 out_bit;
    logic                 fill_bit;
    logic [REG_WIDTH-1:0] shifted;
    logic                 can_shift;

    assign out_bit = shift_left_right ? data_out[REG_WIDTH-1] : data_out[0];

`ifdef SHIFT_ROTATE_EN
    assign fill_bit = out_bit;
`else
    assign fill_bit = serial_in;
`endif

    assign shifted = shift_left_right ? {data_out[REG_WIDTH-2:0], fill_bit}
                                      : {fill_bit, data_out[REG_WIDTH-1:1]};

    // Only a word that still holds unshifted bits may move.
    assign can_shift = shift_en && ((state == LOADED) || (state == SHIFTING));

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            serial_out <= 1'b0;
            shift_cnt  <= '0;
            busy       <= 1'b0;
            drained    <= 1'b0;
            state      <= IDLE;
        end else if (load) begin
            data_out  <= data_in;
            shift_cnt <= '0;
            busy      <= 1'b1;
            drained   <= 1'b0;
            state     <= LOADED;
        end else if (can_shift) begin
            serial_out <= out_bit;
            data_out   <= shifted;
            shift_cnt  <= shift_cnt + 1'b1;
            if (shift_cnt == LAST_CNT) begin
                busy    <= 1'b0;
                drained <= 1'b1;
                state   <= DRAINED;
            end else begin
                state <= SHIFTING;
            end
        end
    end

endmodule

// File: tb/tb_shift_reg_serializer.sv
// Scoreboard bench for shift_reg_serializer: per-cycle expected outputs from a word-level model.
// Define SHIFT_ROTATE_EN for the rotate build.
module tb_shift_reg_serializer;

    localparam int W     = 8;
    localparam int CW    = $clog2(W + 1);
    localparam int EW    = W + 1 + CW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic          shift_left_right = 1'b0;
    logic          shift_en = 1'b0;
    logic          serial_in = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          serial_out;
    logic [CW-1:0] shift_cnt;
    logic          busy;
    logic          drained;
    logic [1:0]    state;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model: the word, last bit out, shifts since load, and whether a word is held.
    logic [W-1:0] m_data  = '0;
    logic         m_sout  = 1'b0;
    int           m_cnt   = 0;
    bit           m_armed = 1'b0;

    shift_reg_serializer #(.REG_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .load(load), .shift_left_right(shift_left_right),
        .shift_en(shift_en), .serial_in(serial_in), .data_in(data_in),
        .data_out(data_out), .serial_out(serial_out), .shift_cnt(shift_cnt),
        .busy(busy), .drained(drained), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] pack_exp();
        logic b, d;
        b = m_armed && (m_cnt < W);
        d = m_armed && (m_cnt == W);
        return {m_data, m_sout, CW'(m_cnt), b, d};
    endfunction

    task automatic model_step(input bit r, input bit ld, input bit left, input bit en,
                              input bit sin, input logic [W-1:0] din);
        bit outb, fill;
        if (r) begin
            m_data = '0; m_sout = 1'b0; m_cnt = 0; m_armed = 1'b0;
        end else if (ld) begin
            m_data = din; m_cnt = 0; m_armed = 1'b1;
        end else if (en && m_armed && m_cnt < W) begin
            outb = left ? m_data[W-1] : m_data[0];
`ifdef SHIFT_ROTATE_EN
            fill = outb;
`else
            fill = sin;
`endif
            if (left) m_data = W'((int'(m_data) * 2) % (1 << W) + int'(fill));
            else      m_data = W'(int'(m_data) / 2 + int'(fill) * (1 << (W - 1)));
            m_sout = outb;
            m_cnt  = m_cnt + 1;
        end
    endtask

    task automatic drive(input bit r, input bit ld, input bit left, input bit en,
                         input bit sin, input logic [W-1:0] din);
        @(negedge clk);
        rst = r; load = ld; shift_left_right = left; shift_en = en;
        serial_in = sin; data_in = din;
        model_step(r, ld, left, en, sin, din);
        exp_q.push_back(pack_exp());
    endtask

    task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: outputs change at every posedge, so every cycle is one observed output.
    initial begin
        logic [EW-1:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {data_out, serial_out, shift_cnt, busy, drained};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL cycle_outputs @%0t: got data=%h sout=%b cnt=%0d busy=%b drained=%b, expected data=%h sout=%b cnt=%0d busy=%b drained=%b",
                             $time, a[EW-1 -: W], a[CW+2], a[CW+1:2], a[1], a[0],
                             e[EW-1 -: W], e[CW+2], e[CW+1:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int waited;
        // Reset with random side inputs
        for (int i = 0; i < 2; i++)
            drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
        @(posedge clk); #2;
        check_val("reset_data", data_out, 8'h00);
        check_val("reset_flags", {4'h0, serial_out, busy, drained, |shift_cnt}, 8'h00);

        // Load 0x01, one left shift
        drive(0, 1, 0, 0, 0, 8'h01);
        drive(0, 0, 1, 1, 0, 8'h00);
        @(posedge clk); #2;
        check_val("left1_data", data_out, 8'h02);
        check_val("left1_cnt_busy", {3'b0, serial_out, shift_cnt}, {3'b0, 1'b0, 4'd1});
        check_val("left1_busy", {7'b0, busy}, 8'h01);

        // Load 0xA5, eight right shifts with serial_in=1, then one more
        drive(0, 1, 0, 0, 0, 8'hA5);
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 1, 8'h00);
        @(posedge clk); #2;
        check_val("drain_data", data_out, 8'hFF);
        check_val("drain_cnt", {4'b0, shift_cnt}, 8'd8);
        check_val("drain_flags", {6'b0, busy, drained}, 8'h01);

        // Simultaneous load and shift_en
        drive(0, 1, 1, 1, 1, 8'h3C);
        @(posedge clk); #2;
        check_val("load_prio_data", data_out, 8'h3C);
        check_val("load_prio_cnt", {4'b0, shift_cnt}, 8'd0);

        // Reset mid-word, then shift_en in IDLE
        drive(0, 1, 0, 0, 0, 8'hF0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 8'h00);
        drive(1, 0, 1, 1, 1, 8'h00);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 1, 8'h00);
        @(posedge clk); #2;
        check_val("idle_ignore", data_out, 8'h00);
        check_val("idle_flags", {3'b0, serial_out, busy, drained, shift_cnt[1:0]}, 8'h00);

`ifdef SHIFT_ROTATE_EN
        drive(0, 1, 0, 0, 0, 8'h81);
        drive(0, 0, 1, 1, 0, 8'h00);
        @(posedge clk); #2;
        check_val("rotate_data", data_out, 8'h03);
        check_val("rotate_sout", {7'b0, serial_out}, 8'h01);
`endif

        // Randomized traffic, mixed directions within words
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
                  1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), W'($urandom));
        drive(0, 0, 0, 0, 0, 8'h00);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
